// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner: shadows BCD digits on load, rotates
// one active-low digit enable per DIV clocks, with optional leading-zero blanking.
module display_scan #(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_th,
    input  logic [3:0] bcd_hun,
    input  logic [3:0] bcd_ten,
    input  logic [3:0] bcd_one,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [3:0]    sh_th;
    logic [3:0]    sh_hun;
    logic [3:0]    sh_ten;
    logic [3:0]    sh_one;
    logic [CW-1:0] div_cnt;
    logic [1:0]    idx;
    logic          tick;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign tick = (div_cnt == LAST);

    // Active-low abcdefg patterns; anything outside 0..9 renders as a dash.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h01;
            4'd1:    s = 7'h4F;
            4'd2:    s = 7'h12;
            4'd3:    s = 7'h06;
            4'd4:    s = 7'h4C;
            4'd5:    s = 7'h24;
            4'd6:    s = 7'h20;
            4'd7:    s = 7'h0F;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h04;
            default: s = 7'h7E;
        endcase
        return s;
    endfunction

    // A slot is blank only when its digit and every more-significant digit are zero.
    always_comb begin
        digit = sh_one;
        blank = 1'b0;
        case (idx)
            2'd0: begin
                digit = sh_one;
                blank = 1'b0;
            end
            2'd1: begin
                digit = sh_ten;
                blank = (sh_th == 4'd0) && (sh_hun == 4'd0) && (sh_ten == 4'd0);
            end
            2'd2: begin
                digit = sh_hun;
                blank = (sh_th == 4'd0) && (sh_hun == 4'd0);
            end
            default: begin
                digit = sh_th;
                blank = (sh_th == 4'd0);
            end
        endcase
        blank    = blank && blank_lz;
        seg_next = blank ? 7'h7F : encode(digit);
        an_next  = blank ? 4'hF : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_th   <= 4'd0;
            sh_hun  <= 4'd0;
            sh_ten  <= 4'd0;
            sh_one  <= 4'd0;
            div_cnt <= '0;
            idx     <= 2'd0;
            seg     <= 7'h7F;
            an      <= 4'hF;
        end else begin
            if (load) begin
                sh_th  <= bcd_th;
                sh_hun <= bcd_hun;
                sh_ten <= bcd_ten;
                sh_one <= bcd_one;
            end
            if (tick) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIV=4: every slot lasts four clocks, so
// edge e (counted from the first edge after reset release) shows slot ((e-1)/4)%4.
module tb_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd_th;
    logic [3:0] bcd_hun;
    logic [3:0] bcd_ten;
    logic [3:0] bcd_one;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    display_scan #(.DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_th   (bcd_th),
        .bcd_hun  (bcd_hun),
        .bcd_ten  (bcd_ten),
        .bcd_one  (bcd_one),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, then edge 1 captures the digits; outputs at edge 1 still
    // reflect the cleared shadow (ones slot, zero).
    task automatic reset_and_load(input logic [3:0] th, input logic [3:0] hun,
                                  input logic [3:0] ten, input logic [3:0] one,
                                  input logic blz);
        rst  = 1'b1;
        load = 1'b0;
        step();
        step();
        rst      = 1'b0;
        load     = 1'b1;
        bcd_th   = th;
        bcd_hun  = hun;
        bcd_ten  = ten;
        bcd_one  = one;
        blank_lz = blz;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b1;
        bcd_th = 4'd8; bcd_hun = 4'd8; bcd_ten = 4'd8; bcd_one = 4'd8;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (an !== 4'hF) begin
                errors++;
                $display("[TB] FAIL reset_an: got %h expected %h", an, 4'hF);
            end
            checks++;
            if (seg !== 7'h7F) begin
                errors++;
                $display("[TB] FAIL reset_seg: got %h expected %h", seg, 7'h7F);
            end
        end
        rst  = 1'b0;
        load = 1'b0;
        step();
        checks++;
        if (an !== 4'hE) begin
            errors++;
            $display("[TB] FAIL release_an: got %h expected %h", an, 4'hE);
        end
        checks++;
        if (seg !== 7'h01) begin
            errors++;
            $display("[TB] FAIL release_seg_priority: got %h expected %h", seg, 7'h01);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        int s;
        ea[0] = 4'hE;  ea[1] = 4'hD;  ea[2] = 4'hB;  ea[3] = 4'h7;
        es[0] = 7'h4C; es[1] = 7'h06; es[2] = 7'h12; es[3] = 7'h4F;
        reset_and_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        checks++;
        if (an !== 4'hE || seg !== 7'h01) begin
            errors++;
            $display("[TB] FAIL scan_first_edge: an=%h seg=%h expected an=E seg=01", an, seg);
        end
        for (int e = 2; e <= 17; e++) begin
            step();
            s = ((e - 1) / 4) % 4;
            checks++;
            if (an !== ea[s]) begin
                errors++;
                $display("[TB] FAIL scan_an e%0d: got %h expected %h", e, an, ea[s]);
            end
            checks++;
            if (seg !== es[s]) begin
                errors++;
                $display("[TB] FAIL scan_seg e%0d: got %h expected %h", e, seg, es[s]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        int s;
        ea[0] = 4'hE;  ea[1] = 4'hD;  ea[2] = 4'hF;  ea[3] = 4'hF;
        es[0] = 7'h01; es[1] = 7'h24; es[2] = 7'h7F; es[3] = 7'h7F;
        reset_and_load(4'd0, 4'd0, 4'd5, 4'd0, 1'b1);
        for (int e = 2; e <= 32; e++) begin
            if (e == 17) begin
                blank_lz = 1'b0;
                ea[2] = 4'hB;  ea[3] = 4'h7;
                es[2] = 7'h01; es[3] = 7'h01;
            end
            step();
            s = ((e - 1) / 4) % 4;
            checks++;
            if (an !== ea[s]) begin
                errors++;
                $display("[TB] FAIL blank_an e%0d: got %h expected %h", e, an, ea[s]);
            end
            checks++;
            if (seg !== es[s]) begin
                errors++;
                $display("[TB] FAIL blank_seg e%0d: got %h expected %h", e, seg, es[s]);
            end
        end
    endtask

    task automatic test_all_zero();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        int s;
        ea[0] = 4'hE;  ea[1] = 4'hF;  ea[2] = 4'hF;  ea[3] = 4'hF;
        es[0] = 7'h01; es[1] = 7'h7F; es[2] = 7'h7F; es[3] = 7'h7F;
        reset_and_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int e = 2; e <= 16; e++) begin
            step();
            s = ((e - 1) / 4) % 4;
            checks++;
            if (an !== ea[s] || seg !== es[s]) begin
                errors++;
                $display("[TB] FAIL all_zero e%0d: an=%h seg=%h expected an=%h seg=%h",
                         e, an, seg, ea[s], es[s]);
            end
        end
    endtask

    task automatic test_non_bcd();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        int s;
        ea[0] = 4'hE;  ea[1] = 4'hF;  ea[2] = 4'hF;  ea[3] = 4'hF;
        es[0] = 7'h7E; es[1] = 7'h7F; es[2] = 7'h7F; es[3] = 7'h7F;
        reset_and_load(4'd0, 4'd0, 4'd0, 4'hB, 1'b1);
        for (int e = 2; e <= 16; e++) begin
            step();
            s = ((e - 1) / 4) % 4;
            checks++;
            if (an !== ea[s] || seg !== es[s]) begin
                errors++;
                $display("[TB] FAIL non_bcd e%0d: an=%h seg=%h expected an=%h seg=%h",
                         e, an, seg, ea[s], es[s]);
            end
        end
    endtask

    task automatic test_digits();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        int s;
        ea[0] = 4'hE;  ea[1] = 4'hD;  ea[2] = 4'hB;  ea[3] = 4'h7;
        es[0] = 7'h04; es[1] = 7'h00; es[2] = 7'h01; es[3] = 7'h20;
        reset_and_load(4'd6, 4'd0, 4'd8, 4'd9, 1'b1);
        for (int e = 2; e <= 16; e++) begin
            step();
            s = ((e - 1) / 4) % 4;
            checks++;
            if (an !== ea[s] || seg !== es[s]) begin
                errors++;
                $display("[TB] FAIL digits e%0d: an=%h seg=%h expected an=%h seg=%h",
                         e, an, seg, ea[s], es[s]);
            end
        end
    endtask

    task automatic test_mid_load();
        logic [3:0] ea [5];
        logic [6:0] es [5];
        ea[0] = 4'hD;  ea[1] = 4'hD;  ea[2] = 4'hD;  ea[3] = 4'hD;  ea[4] = 4'hB;
        es[0] = 7'h06; es[1] = 7'h06; es[2] = 7'h0F; es[3] = 7'h0F; es[4] = 7'h12;
        reset_and_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        for (int e = 2; e <= 4; e++) step();
        for (int e = 5; e <= 9; e++) begin
            load    = (e == 6);
            bcd_ten = 4'd7;
            step();
            load = 1'b0;
            checks++;
            if (an !== ea[e-5] || seg !== es[e-5]) begin
                errors++;
                $display("[TB] FAIL mid_load e%0d: an=%h seg=%h expected an=%h seg=%h",
                         e, an, seg, ea[e-5], es[e-5]);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_and_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        for (int e = 2; e <= 15; e++) step();
        load    = 1'b1;
        bcd_one = 4'd9;
        step();
        load = 1'b0;
        checks++;
        if (an !== 4'h7 || seg !== 7'h4F) begin
            errors++;
            $display("[TB] FAIL tick_load_edge: an=%h seg=%h expected an=7 seg=4F", an, seg);
        end
        for (int e = 17; e <= 18; e++) begin
            step();
            checks++;
            if (an !== 4'hE || seg !== 7'h04) begin
                errors++;
                $display("[TB] FAIL tick_load_after e%0d: an=%h seg=%h expected an=E seg=04",
                         e, an, seg);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        reset_and_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        for (int e = 2; e <= 9; e++) step();
        checks++;
        if (an !== 4'hB || seg !== 7'h12) begin
            errors++;
            $display("[TB] FAIL pre_reset_hundreds: an=%h seg=%h expected an=B seg=12", an, seg);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL mid_reset_edge: an=%h seg=%h expected an=F seg=7F", an, seg);
        end
        for (int e = 11; e <= 15; e++) begin
            step();
            checks++;
            if (e < 15 && (an !== 4'hE || seg !== 7'h01)) begin
                errors++;
                $display("[TB] FAIL after_reset e%0d: an=%h seg=%h expected an=E seg=01",
                         e, an, seg);
            end else if (e == 15 && (an !== 4'hD || seg !== 7'h01)) begin
                errors++;
                $display("[TB] FAIL after_reset e%0d: an=%h seg=%h expected an=D seg=01",
                         e, an, seg);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        bcd_th   = 4'd0;
        bcd_hun  = 4'd0;
        bcd_ten  = 4'd0;
        bcd_one  = 4'd0;
        test_reset();
        test_scan();
        test_blanking();
        test_all_zero();
        test_non_bcd();
        test_digits();
        test_mid_load();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter: DIV, default 50000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 clk  input  1  system clock; every register in the block updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 bcd_th  input  4  thousands BCD digit from the frequency-counter latch stage.
REQ-005 bcd_hun  input  4  hundreds BCD digit.
REQ-006 bcd_ten  input  4  tens BCD digit.
REQ-007 bcd_one  input  4  ones BCD digit.
REQ-008 load  input  1  when high at a clk edge, all four digits are captured into the shadow registers.
REQ-009 blank_lz  input  1  when high, leading zeros are blanked.
REQ-010 seg  output  7  segments {a,b,c,d,e,f,g} on bits 6..0, active-low, registered.
REQ-011 an  output  4  digit enables, active-low, registered; bit0 = ones, bit3 = thousands.

Function
REQ-012 Shadow capture: four 4-bit shadow registers SHALL load bcd_* at every clk edge with load=1 and SHALL hold otherwise; the display SHALL be driven only from the shadow registers.
REQ-013 Divider: counter div_cnt SHALL count 0..DIV-1 and then wrap to 0; tick SHALL be asserted when div_cnt == DIV-1.
REQ-014 Scan index: 2-bit idx SHALL advance 0->1->2->3->0 on each tick and hold otherwise; idx 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.
REQ-015 Output register: at each edge, an SHALL get a one-cold value with bit idx low, and seg SHALL get the encoding of shadow[idx], both evaluated from the pre-edge idx and shadow values (one-cycle latency).
REQ-016 Encoding, active-low abcdefg: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04.
REQ-017 Non-BCD digit values 10..15 SHALL display a dash, seg=7'h7E (only g lit), and are never blanked.
REQ-018 Leading-zero blanking (blank_lz=1): thousands is blank if th==0; hundreds is blank if th==0 and hun==0; tens is blank if th, hun and ten are all 0; ones is never blanked.
REQ-019 Blanked slot: an SHALL be 4'hF and seg SHALL be 7'h7F for the full slot; idx still advances normally.
REQ-020 Simultaneous load and tick: both SHALL take effect at the same edge; the next output register update SHALL use the new idx and the new shadow values.
REQ-021 A load mid-slot SHALL change seg at the next edge without restarting div_cnt or idx.
REQ-022 blank_lz SHALL be sampled live, not shadowed; a change SHALL take effect at the next edge.

Reset
REQ-023 With rst=1 at an edge, shadow registers, div_cnt and idx SHALL all be set to 0, an SHALL be 4'hF and seg SHALL be 7'h7F.
REQ-024 rst SHALL take priority over load and tick.
REQ-025 At the first edge after rst is released, outputs SHALL show the ones slot: an=4'hE and seg = encoding of shadow ones (7'h01 after reset).
REQ-026 Reset asserted mid-scan SHALL abort the current slot with no residual state.

Verification
REQ-027 DIV=4, load 1,2,3,4 (th..one), blank_lz=0 -> an cycles E,D,B,7, each slot held 4 clocks; seg cycles 4C,06,12,4F in that order.
REQ-028 Load 0,0,5,0 with blank_lz=1 -> thousands and hundreds slots give an=F, seg=7F; tens gives seg=24; ones gives seg=01; with blank_lz=0 all four slots are lit, zeros shown as 01.
REQ-029 Load 0,0,0,0 with blank_lz=1 -> only the ones slot is lit (an=E, seg=01); the other three slots give an=F.
REQ-030 Load ones=4'hB -> the ones slot gives seg=7E, not blanked.
REQ-031 load asserted on the same cycle as tick with new ones=9 -> idx wraps to 0 and the next edge gives an=E, seg=04.
REQ-032 rst pulsed during the hundreds slot -> the same edge gives an=F, seg=7F; the next edge gives an=E; the shadow registers read 0.
